// File: rtl/uart_txq_pkg.sv
// uart_txq_pkg: register offsets, STATUS/CTRL bit positions and the
// serializer state encoding shared by the UART transmit-queue block.
// Optional parity support is selected with the UART_TXQ_PARITY_EN macro.
package uart_txq_pkg;

  // Word offsets on the 3-bit address bus
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_DIV    = 3'd3;

  // STATUS bit positions
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;

  // CTRL bit positions
  localparam int CT_TX_EN   = 0;
  localparam int CT_IRQ_EN  = 1;
  localparam int CT_PAR_EN  = 2;
  localparam int CT_PAR_ODD = 3;
  localparam int CT_THR     = 8;

`ifdef UART_TXQ_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;
`endif

  // A divisor of zero would never advance the baud counter, so run it as 1
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_txq_fifo.sv
// uart_txq_fifo: byte FIFO of 2**DEPTH_LOG2 entries. The head entry is read
// combinationally so the serializer can load it in the same cycle it pops.
// A push while full is accepted only when a pop frees a slot in that cycle.
module uart_txq_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Storage array: no reset, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and occupancy; a flushed FIFO is simply pointers back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (!do_push && do_pop) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/uart_txq.sv
// uart_txq: memory-mapped UART transmit queue. CPU stores fill a byte FIFO,
// an 8N1 serializer drains it on uart_txd, and a registered level irq fires
// when the queue occupancy is at or below a programmable threshold.
// Define UART_TXQ_PARITY_EN to add CTRL par_en/par_odd and a parity bit slot.
module uart_txq
  import uart_txq_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 4,
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic [2:0]  addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        irq,
  output logic        uart_txd
);

  // Register file
  logic        tx_en_reg;
  logic        irq_en_reg;
  logic [3:0]  thr_reg;
  logic [15:0] div_reg;
  logic        ovf_reg;
  logic        irq_reg;
`ifdef UART_TXQ_PARITY_EN
  logic        par_en_reg;
  logic        par_odd_reg;
  logic        par_bit_reg, par_bit_next;
  logic        par_use_reg, par_use_next;
`endif

  // Serializer state
  tx_state_t   state_reg, state_next;
  logic [15:0] baud_reg, baud_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic [15:0] div_lat_reg, div_lat_next;
  logic        pop;
  logic        txd;

  // FIFO interface
  logic                push;
  logic [7:0]          head;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;

  logic wr_status, wr_ctrl, wr_div;
  logic busy;
  logic unused_wdata;

  assign push      = write_enable & (addr == REG_DATA);
  assign wr_status = write_enable & (addr == REG_STATUS);
  assign wr_ctrl   = write_enable & (addr == REG_CTRL);
  assign wr_div    = write_enable & (addr == REG_DIV);
  assign busy      = (state_reg != S_IDLE);
  assign irq       = irq_reg;
  assign uart_txd  = txd;
  assign unused_wdata = ^write_data[31:16];

  uart_txq_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk       (clk),
    .rst_n     (sys_rstn),
    .push      (push),
    .push_data (write_data[7:0]),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Register writes, sticky overflow flag and registered irq level
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      tx_en_reg   <= 1'b0;
      irq_en_reg  <= 1'b0;
      thr_reg     <= 4'd0;
      div_reg     <= 16'(DEFAULT_DIV);
      ovf_reg     <= 1'b0;
      irq_reg     <= 1'b0;
`ifdef UART_TXQ_PARITY_EN
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) begin
        tx_en_reg   <= write_data[CT_TX_EN];
        irq_en_reg  <= write_data[CT_IRQ_EN];
        thr_reg     <= write_data[CT_THR +: 4];
`ifdef UART_TXQ_PARITY_EN
        par_en_reg  <= write_data[CT_PAR_EN];
        par_odd_reg <= write_data[CT_PAR_ODD];
`endif
      end
      if (wr_div) div_reg <= write_data[15:0];
      // A dropped byte is one pushed into a full FIFO that is not popping
      if (push && full && !pop)                ovf_reg <= 1'b1;
      else if (wr_status && write_data[ST_OVF]) ovf_reg <= 1'b0;
      irq_reg <= irq_en_reg & (32'(count) <= 32'(thr_reg));
    end
  end

  // Serializer state register
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_reg   <= S_IDLE;
      baud_reg    <= 16'd0;
      bit_reg     <= 3'd0;
      shift_reg   <= 8'd0;
      div_lat_reg <= 16'd1;
`ifdef UART_TXQ_PARITY_EN
      par_bit_reg <= 1'b0;
      par_use_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      div_lat_reg <= div_lat_next;
`ifdef UART_TXQ_PARITY_EN
      par_bit_reg <= par_bit_next;
      par_use_reg <= par_use_next;
`endif
    end
  end

  // Serializer next state and line output; each bit slot lasts div_lat cycles
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    div_lat_next = div_lat_reg;
    pop          = 1'b0;
    txd          = 1'b1;
`ifdef UART_TXQ_PARITY_EN
    par_bit_next = par_bit_reg;
    par_use_next = par_use_reg;
`endif
    // Every non-idle slot counts down and reloads the latched divisor
    if (state_reg != S_IDLE) begin
      baud_next = (baud_reg == 16'd0) ? (div_lat_reg - 16'd1) : (baud_reg - 16'd1);
    end
    case (state_reg)
      S_IDLE: begin
        if (tx_en_reg && !empty) begin
          pop          = 1'b1;
          shift_next   = head;
          div_lat_next = eff_div(div_reg);
          baud_next    = eff_div(div_reg) - 16'd1;
          state_next   = S_START;
`ifdef UART_TXQ_PARITY_EN
          par_bit_next = (^head) ^ par_odd_reg;
          par_use_next = par_en_reg;
`endif
        end
      end
      S_START: begin
        txd = 1'b0;
        if (baud_reg == 16'd0) begin
          state_next = S_DATA;
          bit_next   = 3'd0;
        end
      end
      S_DATA: begin
        txd = shift_reg[0];
        if (baud_reg == 16'd0) begin
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_TXQ_PARITY_EN
            state_next = par_use_reg ? S_PARITY : S_STOP;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TXQ_PARITY_EN
      S_PARITY: begin
        txd = par_bit_reg;
        if (baud_reg == 16'd0) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        txd = 1'b1;
        if (baud_reg == 16'd0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Combinational read mux so the bridge samples data in the access cycle
  always_comb begin
    read_result = 32'd0;
    case (addr)
      REG_STATUS: begin
        read_result[ST_FULL]  = full;
        read_result[ST_EMPTY] = empty;
        read_result[ST_BUSY]  = busy;
        read_result[ST_OVF]   = ovf_reg;
        read_result[ST_COUNT +: DEPTH_LOG2+1] = count;
      end
      REG_CTRL: begin
        read_result[CT_TX_EN]     = tx_en_reg;
        read_result[CT_IRQ_EN]    = irq_en_reg;
        read_result[CT_THR +: 4]  = thr_reg;
`ifdef UART_TXQ_PARITY_EN
        read_result[CT_PAR_EN]    = par_en_reg;
        read_result[CT_PAR_ODD]   = par_odd_reg;
`endif
      end
      REG_DIV: read_result[15:0] = div_reg;
      default: read_result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_txq.sv
// tb_uart_txq: self-checking bench for uart_txq. A free-running line receiver
// decodes frames from uart_txd into a queue; tests compare those frames and
// register reads against expectations computed from the register/frame rules.
`timescale 1ns/1ps
module tb_uart_txq;

  localparam logic [2:0] A_DATA = 3'd0, A_STATUS = 3'd1, A_CTRL = 3'd2, A_DIV = 3'd3;

  logic        clk = 1'b0;
  logic        sys_rstn = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic        write_enable = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_result;
  logic        irq;
  logic        uart_txd;

  uart_txq dut (
    .clk          (clk),
    .sys_rstn     (sys_rstn),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_result  (read_result),
    .irq          (irq),
    .uart_txd     (uart_txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-16s got 0x%08h exp 0x%08h ok", name, got, exp);
    end else begin
      $display("FAIL %-16s got 0x%08h exp 0x%08h", name, got, exp);
    end
  endtask

  // Bus access helpers: all driving happens in the clock-low phase
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; write_data = d; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1;
    d = read_result;
  endtask

  // ---------------- line receiver ----------------
  typedef struct { logic [7:0] data; bit good; int gap; } rx_t;
  rx_t rx_q[$];
  int  rx_div = 434;
  bit  rx_par_en = 1'b0;
  bit  rx_par_odd = 1'b0;

  // Decode one frame whose first start-bit sample has just been taken
  task automatic rx_frame(input int gap);
    rx_t r; logic [7:0] d; logic v; bit ok; int nslots; int dv; bit pe; bit po;
    ok = 1'b1; d = 8'd0; v = 1'b0;
    dv = rx_div; pe = rx_par_en; po = rx_par_odd;
    nslots = pe ? 11 : 10;
    for (int s = 0; s < nslots; s++) begin
      for (int c = 0; c < dv; c++) begin
        if (s != 0 || c != 0) begin
          @(negedge clk);
          if (!sys_rstn) return;
        end
        if (c == 0) v = uart_txd;
        else if (uart_txd !== v) ok = 1'b0;
      end
      if (s >= 1 && s <= 8) d[s-1] = v;
      if (pe && s == 9 && v !== ((^d) ^ po)) ok = 1'b0;
      if (s == nslots - 1 && v !== 1'b1) ok = 1'b0;
    end
    r.data = d; r.good = ok; r.gap = gap;
    rx_q.push_back(r);
  endtask

  initial begin : rx_mon
    int idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!sys_rstn) idle = 0;
      else if (uart_txd === 1'b1) idle++;
      else begin
        rx_frame(idle);
        idle = 0;
      end
    end
  end

  // Wait (bounded) until n frames have been received
  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check("frames_rx", rx_q.size(), n);
  endtask

  // Compare received frames against an expected byte list
  task automatic check_frames(input string tag, input logic [7:0] exp_q[$], input bit gaps);
    rx_t r;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rx_q.size() == 0) break;
      r = rx_q.pop_front();
      check($sformatf("%s_d%0d", tag, i), r.data, exp_q[i]);
      check($sformatf("%s_ok%0d", tag, i), r.good, 1);
      if (gaps && i > 0) check($sformatf("%s_gap%0d", tag, i), r.gap, 1);
    end
  endtask

  // ---------------- table-driven register vectors ----------------
  typedef struct {
    bit          wr;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [31:0] exp;
  } vec_t;

`ifdef UART_TXQ_PARITY_EN
  localparam logic [31:0] CTRL_ALL = 32'h0000_0F0F;
`else
  localparam logic [31:0] CTRL_ALL = 32'h0000_0F03;
`endif

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vt [14];
    logic [31:0] rd;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    int          n, dv, cnt, mism;
    logic [31:0] exp_st;
    bit          exp_irq;

    vt[0]  = '{1'b0, A_DATA,   32'd0,          3'd0,     32'd0};
    vt[1]  = '{1'b0, A_DATA,   32'd0,          A_STATUS, 32'h0000_0002};
    vt[2]  = '{1'b0, A_DATA,   32'd0,          A_CTRL,   32'd0};
    vt[3]  = '{1'b0, A_DATA,   32'd0,          A_DIV,    32'd434};
    vt[4]  = '{1'b0, A_DATA,   32'd0,          3'd4,     32'd0};
    vt[5]  = '{1'b0, A_DATA,   32'd0,          3'd5,     32'd0};
    vt[6]  = '{1'b0, A_DATA,   32'd0,          3'd6,     32'd0};
    vt[7]  = '{1'b0, A_DATA,   32'd0,          3'd7,     32'd0};
    vt[8]  = '{1'b1, A_CTRL,   32'hFFFF_FFFF,  A_CTRL,   CTRL_ALL};
    vt[9]  = '{1'b1, A_CTRL,   32'h0000_0000,  A_CTRL,   32'd0};
    vt[10] = '{1'b1, A_DIV,    32'hABCD_1234,  A_DIV,    32'h0000_1234};
    vt[11] = '{1'b1, 3'd5,     32'hFFFF_FFFF,  3'd5,     32'd0};
    vt[12] = '{1'b1, A_STATUS, 32'hFFFF_FFFF,  A_STATUS, 32'h0000_0002};
    vt[13] = '{1'b1, A_DIV,    32'h0000_0004,  A_DIV,    32'd4};

    // Reset
    repeat (3) @(negedge clk);
    sys_rstn = 1'b1;
    @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_irq", irq, 0);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) bus_write(vt[i].wa, vt[i].wd);
      bus_read(vt[i].ra, rd);
      check($sformatf("tbl%0d", i), rd, vt[i].exp);
    end

    // Single 0xA5 frame at DIV=4
    rx_div = 4;
    rx_q.delete();
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'hA5);
    bus_read(A_STATUS, rd);
    check("a5_busy", rd, 32'h0000_0006);
    wait_frames(1, 100);
    exp_q = '{8'hA5};
    check_frames("a5", exp_q, 1'b0);
    bus_read(A_STATUS, rd);
    check("a5_idle", rd, 32'h0000_0002);
    bus_write(A_CTRL, 32'h0);

    // Randomized fill / overflow / drain against a queue model
    for (int it = 0; it < 4; it++) begin
      n  = (it == 0) ? 17 : $urandom_range(0, 20);
      dv = (it == 0) ? 4  : $urandom_range(0, 4);
      bus_write(A_DIV, dv);
      rx_div = (dv == 0) ? 1 : dv;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        bus_write(A_DATA, {24'd0, b});
        if (exp_q.size() < 16) exp_q.push_back(b);
      end
      cnt = exp_q.size();
      exp_st = {19'd0, 5'(cnt), 4'd0, (n > 16), 1'b0, (cnt == 0), (cnt == 16)};
      bus_read(A_STATUS, rd);
      check($sformatf("rnd%0d_st", it), rd, exp_st);
      bus_write(A_STATUS, 32'h8);
      bus_read(A_STATUS, rd);
      check($sformatf("rnd%0d_w1c", it), rd, exp_st & ~32'h8);
      rx_q.delete();
      bus_write(A_CTRL, 32'h1);
      wait_frames(cnt, cnt * (10 * rx_div + 1) + 20);
      check_frames($sformatf("rnd%0d", it), exp_q, 1'b1);
      bus_write(A_CTRL, 32'h0);
    end

    // Full FIFO, push in the same cycle as the first pop
    bus_write(A_DIV, 32'd3);
    rx_div = 3;
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      bus_write(A_DATA, {24'd0, b});
      exp_q.push_back(b);
    end
    bus_read(A_STATUS, rd);
    check("col_full", rd, 32'h0000_1001);
    rx_q.delete();
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'h77);
    exp_q.push_back(8'h77);
    bus_read(A_STATUS, rd);
    check("col_st", rd, 32'h0000_1005);
    wait_frames(17, 17 * 31 + 50);
    check_frames("col", exp_q, 1'b1);
    bus_read(A_STATUS, rd);
    check("col_end", rd, 32'h0000_0002);
    bus_write(A_CTRL, 32'h0);

    // Low-water irq: 5 bytes at DIV=2, threshold 2; frame period 10*2+1
    bus_write(A_DIV, 32'd2);
    rx_div = 2;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      bus_write(A_DATA, {24'd0, b});
      exp_q.push_back(b);
    end
    rx_q.delete();
    bus_write(A_CTRL, 32'h0000_0203);
    mism = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      // third pop lands 1 + 2*21 cycles after enabling; irq follows a cycle later
      exp_irq = (j >= 1 + 2 * 21 + 1);
      if (irq !== exp_irq) mism++;
      if (j == 43) check("irq_pre", irq, 0);
      if (j == 44) check("irq_post", irq, 1);
    end
    check("irq_timeline", mism, 0);
    bus_write(A_CTRL, 32'h0000_0201);
    check("irq_hold", irq, 1);
    @(negedge clk);
    check("irq_off", irq, 0);
    wait_frames(5, 200);
    check_frames("irq", exp_q, 1'b1);

`ifdef UART_TXQ_PARITY_EN
    // Odd parity frame
    bus_write(A_CTRL, 32'h0000_000D);
    rx_par_en = 1'b1; rx_par_odd = 1'b1;
    rx_q.delete();
    bus_write(A_DATA, 32'h5A);
    wait_frames(1, 100);
    exp_q = '{8'h5A};
    check_frames("par", exp_q, 1'b0);
    rx_par_en = 1'b0; rx_par_odd = 1'b0;
`endif

    // Reset asserted mid-DATA
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DIV, 32'd4);
    rx_div = 4;
    rx_q.delete();
    bus_write(A_DATA, 32'hC3);
    bus_write(A_DATA, 32'h81);
    repeat (10) @(negedge clk);
    sys_rstn = 1'b0;
    #1;
    check("abort_txd", uart_txd, 1);
    addr = A_STATUS;
    #1;
    check("abort_st", read_result, 32'h0000_0002);
    check("abort_irq", irq, 0);
    repeat (2) @(negedge clk);
    sys_rstn = 1'b1;
    check("abort_nofrm", rx_q.size(), 0);
    bus_read(A_DIV, rd);
    check("abort_div", rd, 32'd434);
    bus_read(A_CTRL, rd);
    check("abort_ctrl", rd, 32'd0);
    bus_write(A_DIV, 32'd3);
    rx_div = 3;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_DATA, 32'h3C);
    wait_frames(1, 100);
    exp_q = '{8'h3C};
    check_frames("post", exp_q, 1'b0);
    repeat (40) @(negedge clk);
    check("post_extra", rx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
